// File: rtl/calc_pkg.sv
// calc_pkg: shared calculator types, extended with the display scanner state and brightness types.
package calc_pkg;
  localparam int NumDigits = 4;
  typedef enum logic [1:0] {IDLE, GUARD, ON} scan_state_t;
  typedef logic [3:0] brightness_t;
endpackage

// File: rtl/scan_timer.sv
// scan_timer: loadable down-counter timing the GUARD and ON phases; slot_o is the PWM slot of the upcoming cycle.
module scan_timer #(
  parameter int SlotCycles = 64,
  parameter int Width = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             done_o,
  output logic [3:0]       slot_o
);
  localparam int OnLast = 16 * SlotCycles - 1;
  logic [Width-1:0] cnt, cnt_d;
  assign cnt_d = load_i ? load_val_i : cnt - 1'b1;
  assign done_o = cnt == '0;
  assign slot_o = 4'((OnLast - int'(cnt_d)) / SlotCycles);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt <= '0;
    else cnt <= cnt_d;
endmodule

// File: rtl/segment_scanner.sv
// segment_scanner: multiplexed 7-segment scanner with inter-digit guard, 16-level PWM and per-frame input snapshot.
module segment_scanner
  import calc_pkg::*;
#(
  parameter int NumDigits = calc_pkg::NumDigits,
  parameter int SlotCycles = 64,
  parameter int GuardCycles = 4,
  parameter int AnodeActiveLow = 1,
  parameter int SegActiveLow = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumDigits-1:0][7:0]    segments_i,
  input  logic [3:0]                   brightness_i,
  input  logic                         enable_i,
  output logic [NumDigits-1:0]         anode_o,
  output logic [7:0]                   cathode_o,
  output logic                         frame_o,
  output logic [$clog2(NumDigits)-1:0] digit_o
);
  localparam int DW = $clog2(NumDigits);
  localparam int OnLen = 16 * SlotCycles;
  localparam int CntW = $clog2(OnLen > GuardCycles ? OnLen : GuardCycles);
  localparam logic [CntW-1:0] OnLast = CntW'(OnLen - 1);
  localparam logic [CntW-1:0] GuardLast = CntW'(GuardCycles - 1);
  localparam logic [NumDigits-1:0] AnOff = AnodeActiveLow != 0 ? '1 : '0;
  localparam logic [7:0] SegOff = SegActiveLow != 0 ? 8'hFF : 8'h00;
  scan_state_t st, st_d;
  logic [DW-1:0] dig, dig_d;
  logic [NumDigits-1:0][7:0] snap;
  brightness_t bq;
  logic load, done, capture, lit, last;
  logic [CntW-1:0] load_val;
  logic [3:0] slot;
  scan_timer #(.SlotCycles(SlotCycles), .Width(CntW)) u_timer (
    .clk_i, .rst_i, .load_i(load), .load_val_i(load_val), .done_o(done), .slot_o(slot)
  );
  assign last = dig == DW'(NumDigits - 1);
  assign digit_o = dig;
  always_comb begin
    st_d = st;
    dig_d = dig;
    load = 1'b0;
    load_val = '0;
    capture = 1'b0;
    if (!enable_i) begin
      st_d = IDLE;
      dig_d = '0;
      load = 1'b1;
    end else if (st == IDLE) begin
      st_d = GUARD;
      dig_d = '0;
      load = 1'b1;
      load_val = GuardLast;
      capture = 1'b1;
    end else if (done) begin
      load = 1'b1;
      st_d = st == GUARD ? ON : GUARD;
      load_val = st == GUARD ? OnLast : GuardLast;
      dig_d = st == GUARD ? dig : (last ? '0 : dig + 1'b1);
      capture = st == ON && last;
    end
    lit = st_d == ON && slot <= bq;
  end
  // Outputs are registered from next-state values so they line up with the state they decode.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      st <= IDLE;
      dig <= '0;
      snap <= '0;
      bq <= '0;
      frame_o <= 1'b0;
      anode_o <= AnOff;
      cathode_o <= SegOff;
    end else begin
      st <= st_d;
      dig <= dig_d;
      if (capture) begin
        snap <= segments_i;
        bq <= brightness_i;
      end
      frame_o <= capture;
      anode_o <= lit ? AnOff ^ (NumDigits'(1) << dig_d) : AnOff;
      cathode_o <= lit ? SegOff ^ snap[dig_d] : SegOff;
    end
endmodule

// File: tb/tb_segment_scanner.sv
// tb_segment_scanner: randomized scenarios checked against a frame-position model of the scanner.
module tb_segment_scanner;
  localparam int N = 4, S = 2, G = 1, DP = G + 16 * S, FP = N * DP;
  logic clk = 0, rst_i = 1, enable_i = 0;
  logic [N-1:0][7:0] segments_i = '0;
  logic [3:0] brightness_i = '0;
  logic [N-1:0] anode_o;
  logic [7:0] cathode_o;
  logic frame_o;
  logic [1:0] digit_o;
  int passed = 0, total = 0;
  bit m_act = 0;
  int m_pos = 0, m_b = 0;
  logic [N-1:0][7:0] m_snap = '0;
  logic [14:0] exp_v;

  segment_scanner #(.NumDigits(N), .SlotCycles(S), .GuardCycles(G), .AnodeActiveLow(1), .SegActiveLow(1)) dut (
    .clk_i(clk), .rst_i(rst_i), .segments_i(segments_i), .brightness_i(brightness_i), .enable_i(enable_i),
    .anode_o(anode_o), .cathode_o(cathode_o), .frame_o(frame_o), .digit_o(digit_o)
  );

  always #5 clk = ~clk;

  task automatic clk_step();
    @(posedge clk);
    if (rst_i || !enable_i) m_act = 0;
    else if (!m_act) begin
      m_act = 1; m_pos = 0; m_snap = segments_i; m_b = int'(brightness_i);
    end else begin
      m_pos = (m_pos + 1) % FP;
      if (m_pos == 0) begin m_snap = segments_i; m_b = int'(brightness_i); end
    end
    #1;
  endtask

  function automatic logic [14:0] model_out();
    logic [N-1:0] an = '1;
    logic [7:0] ca = 8'hFF;
    logic fr = 0;
    logic [1:0] dg = 0;
    int d, off;
    if (m_act) begin
      d = m_pos / DP; off = m_pos % DP; dg = 2'(d); fr = m_pos == 0;
      if (off >= G && (off - G) / S <= m_b) begin an[d] = 1'b0; ca = ~m_snap[d]; end
    end
    return {an, ca, fr, dg};
  endfunction

  task automatic restart(input logic [3:0] b);
    enable_i = 0; clk_step();
    brightness_i = b; enable_i = 1; clk_step();
  endtask

  task automatic test_reset();
    rst_i = 1; clk_step(); clk_step();
    total++;
    if ({anode_o, cathode_o, frame_o, digit_o} !== {4'hF, 8'hFF, 1'b0, 2'd0})
      $display("FAIL reset got=%h exp=%h", {anode_o, cathode_o, frame_o, digit_o}, {4'hF, 8'hFF, 1'b0, 2'd0});
    else passed++;
    rst_i = 0; clk_step();
  endtask

  task automatic test_scan();
    segments_i[0] = 8'h3F; segments_i[1] = 8'h06; segments_i[2] = 8'h5B; segments_i[3] = 8'h4F;
    brightness_i = 15; enable_i = 1;
    for (int c = 1; c <= 2 * FP + 2; c++) begin
      clk_step();
      exp_v = model_out(); total++;
      if ({anode_o, cathode_o, frame_o, digit_o} !== exp_v)
        $display("FAIL scan cyc=%0d got=%h exp=%h", c, {anode_o, cathode_o, frame_o, digit_o}, exp_v);
      else passed++;
      if (c == 1 || c == FP + 1) begin
        total++;
        if (frame_o !== 1'b1) $display("FAIL scan_frame cyc=%0d got=%b exp=1", c, frame_o); else passed++;
      end
      if (c == 2 || c == 33) begin
        total++;
        if ({anode_o, cathode_o} !== {4'b1110, 8'hC0}) $display("FAIL scan_d0 cyc=%0d got=%h exp=ec0", c, {anode_o, cathode_o}); else passed++;
      end
      if (c == 34) begin
        total++;
        if (anode_o !== 4'b1111) $display("FAIL scan_guard got=%b exp=1111", anode_o); else passed++;
      end
      if (c == 35) begin
        total++;
        if ({anode_o, cathode_o} !== {4'b1101, 8'hF9}) $display("FAIL scan_d1 got=%h exp=df9", {anode_o, cathode_o}); else passed++;
      end
    end
  endtask

  task automatic test_brightness();
    logic [3:0] lv [2] = '{4'd0, 4'd7};
    int on;
    for (int k = 0; k < 2; k++) begin
      restart(lv[k]);
      on = 0;
      for (int c = 0; c < FP; c++) begin
        if (c > 0) clk_step();
        exp_v = model_out(); total++;
        if ({anode_o, cathode_o, frame_o, digit_o} !== exp_v)
          $display("FAIL bright pos=%0d got=%h exp=%h", m_pos, {anode_o, cathode_o, frame_o, digit_o}, exp_v);
        else passed++;
        if (anode_o[0] === 1'b0) on++;
      end
      total++;
      if (on != (int'(lv[k]) + 1) * S) $display("FAIL bright_duty b=%0d got=%0d exp=%0d", lv[k], on, (int'(lv[k]) + 1) * S);
      else passed++;
    end
  endtask

  task automatic test_midframe();
    logic [7:0] old2;
    segments_i = {$urandom, $urandom};
    restart(4'(15));
    old2 = segments_i[2];
    for (int c = 0; c < 2 * FP; c++) begin
      clk_step();
      if (m_pos == DP + 5) segments_i = {$urandom, $urandom};
      exp_v = model_out(); total++;
      if ({anode_o, cathode_o, frame_o, digit_o} !== exp_v)
        $display("FAIL midframe pos=%0d got=%h exp=%h", m_pos, {anode_o, cathode_o, frame_o, digit_o}, exp_v);
      else passed++;
      if (c < FP && m_pos == 2 * DP + G) begin
        total++;
        if (cathode_o !== ~old2) $display("FAIL midframe_old got=%h exp=%h", cathode_o, ~old2); else passed++;
      end
    end
  endtask

  task automatic test_disable();
    restart(4'($urandom_range(15)));
    for (int c = 0; c < 2 * DP + 10; c++) clk_step();
    enable_i = 0; clk_step();
    total++;
    if ({anode_o, cathode_o, frame_o, digit_o} !== {4'hF, 8'hFF, 1'b0, 2'd0})
      $display("FAIL disable got=%h exp=%h", {anode_o, cathode_o, frame_o, digit_o}, {4'hF, 8'hFF, 1'b0, 2'd0});
    else passed++;
    enable_i = 1; clk_step();
    total++;
    if ({anode_o, frame_o, digit_o} !== {4'hF, 1'b1, 2'd0})
      $display("FAIL reenable got=%h exp=%h", {anode_o, frame_o, digit_o}, {4'hF, 1'b1, 2'd0});
    else passed++;
  endtask

  task automatic test_async_reset();
    restart(4'(15));
    for (int c = 0; c < DP + 7; c++) clk_step();
    #2 rst_i = 1;
    #1;
    m_act = 0;
    total++;
    if ({anode_o, cathode_o, frame_o, digit_o} !== {4'hF, 8'hFF, 1'b0, 2'd0})
      $display("FAIL async_rst got=%h exp=%h", {anode_o, cathode_o, frame_o, digit_o}, {4'hF, 8'hFF, 1'b0, 2'd0});
    else passed++;
    clk_step();
    #2 rst_i = 0;
    for (int c = 1; c <= 40; c++) begin
      clk_step();
      exp_v = model_out(); total++;
      if ({anode_o, cathode_o, frame_o, digit_o} !== exp_v)
        $display("FAIL after_rst cyc=%0d got=%h exp=%h", c, {anode_o, cathode_o, frame_o, digit_o}, exp_v);
      else passed++;
      if (c == 1) begin
        total++;
        if (frame_o !== 1'b1) $display("FAIL after_rst_frame got=%b exp=1", frame_o); else passed++;
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] prev = '0, cur;
    restart(4'($urandom_range(15)));
    for (int c = 0; c < 10 * FP; c++) begin
      if ($urandom_range(40) == 0) segments_i = {$urandom, $urandom};
      if ($urandom_range(40) == 0) brightness_i = 4'($urandom_range(15));
      clk_step();
      exp_v = model_out(); total++;
      if ({anode_o, cathode_o, frame_o, digit_o} !== exp_v)
        $display("FAIL random pos=%0d got=%h exp=%h", m_pos, {anode_o, cathode_o, frame_o, digit_o}, exp_v);
      else passed++;
      cur = ~anode_o;
      total++;
      if ($countones(cur) > 1) $display("FAIL one_anode got=%b exp=at most one low", anode_o); else passed++;
      if (cur != '0 && prev != '0 && cur != prev) begin
        total++;
        $display("FAIL guard_gap got=%b after=%b exp=guard between", cur, prev);
      end
      prev = cur;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_brightness();
    test_midframe();
    test_disable();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/segment_scanner.md
Name: segment_scanner

Overview:
- Downstream of the calculator's per-digit segment output (`display_segments_o`, `NumDigits` × 8 bits).
- Drives a physical multiplexed common-anode 7-segment display (shared cathode bus, one anode per digit).
- Scans the digits in order, with a blanking guard between digits to prevent ghosting.
- Applies 16-level PWM brightness and snapshots its inputs once per frame so a frame never mixes old and new digits.

Parameters:
- NumDigits, calc_pkg::NumDigits, number of digits scanned.
- SlotCycles, 64, clock cycles per PWM slot (≥1). A digit's ON phase is 16 slots.
- GuardCycles, 4, clock cycles all anodes are off before each digit (≥1).
- AnodeActiveLow, 1, 1 means an anode is asserted by driving 0.
- SegActiveLow, 1, 1 means a segment is lit by driving 0.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- segments_i  in  [NumDigits-1:0][7:0]  logical segments, 1 = lit, same bit order as the screen driver
- brightness_i  in  4  brightness level; 0 = 1/16 duty, 15 = full
- enable_i  in  1  scan enable; 0 blanks the display
- anode_o  out  NumDigits  digit strobes, polarity per AnodeActiveLow
- cathode_o  out  8  segment bus, polarity per SegActiveLow
- frame_o  out  1  one-cycle pulse at the start of each frame
- digit_o  out  $clog2(NumDigits)  index of the digit currently being scanned

Behaviour:
- All outputs come from flops and are Moore decodes of the state registers.
- Reset (asynchronous, active-high):
  - state=IDLE, digit=0, counter=0, snapshot=0, brightness_q=0.
  - anode_o all inactive, cathode_o all unlit, frame_o=0, digit_o=0.
- Inactive level: anodes 1 when AnodeActiveLow else 0. Unlit segments 1 when SegActiveLow else 0.
- States: IDLE, GUARD, ON.
- IDLE:
  - outputs inactive.
  - If enable_i=1, next cycle enter GUARD with digit=0 and counter=0.
- GUARD:
  - anodes inactive, cathodes unlit.
  - Lasts exactly GuardCycles cycles, then ON with counter=0.
- ON:
  - Lasts exactly 16*SlotCycles cycles.
  - slot = counter / SlotCycles (0..15).
  - Digit is lit iff slot ≤ brightness_q. When lit: anode_o[digit] active, cathode_o = snapshot[digit] mapped to output polarity. When not lit: as in GUARD.
  - At the end of ON: digit = digit+1 and enter GUARD. If digit was NumDigits-1, wrap to 0; this starts a new frame.
- Frame start = any entry into GUARD with digit=0, whether from IDLE or from the wrap.
  - frame_o=1 for exactly that first GUARD cycle.
  - segments_i is captured into the snapshot and brightness_i into brightness_q on the same clock edge as that entry.
  - Input changes during a frame have no effect until the next frame.
- Timing:
  - Digit period = GuardCycles + 16*SlotCycles.
  - Frame period = NumDigits × digit period.
  - Latency from enable_i rising (while in IDLE) to frame_o = 1 cycle.
- enable_i=0 in any state: next cycle IDLE, counter=0, digit=0, outputs inactive. No partial frame completes.
- enable_i toggling 1→0→1 always restarts at digit 0 with a fresh snapshot.
- At most one anode is active in any cycle. An anode never goes active in the cycle immediately after a different anode was active, because GUARD separates digits.
- Counters are sized for 16*SlotCycles-1 and GuardCycles-1. No overflow is possible.
- digit_o equals the internal digit register in all states (0 in IDLE).

Decomposition:
- calc_pkg additions: `scan_state_t` enum (IDLE, GUARD, ON); `brightness_t` (logic [3:0]). NumDigits stays in calc_pkg.
- One sub-module, `scan_timer`:
  - parameterised down-counter with load and done.
  - reused for the GUARD and ON phases.
  - exposes the slot index.
- The FSM, snapshot, and output polarity mapping live in segment_scanner.

Test Plan:
All scenarios use NumDigits=4, SlotCycles=2, GuardCycles=1, both polarities active-low; digit period 33 cycles, frame 132 cycles.

1. Reset, then enable_i=1 with segments {8'h3F, 8'h06, 8'h5B, 8'h4F} and brightness 15 → frame_o pulses at cycle 1. anode_o=4'b1110 and cathode_o=8'hC0 for cycles 2–33. Cycle 34 is guard (4'b1111). Digit 1 gives anode_o=4'b1101, cathode_o=8'hF9. Frame_o repeats every 132 cycles.
2. brightness_i=0 → each anode is active for 2 of every 33 cycles. brightness_i=7 → active for 16 of 33.
3. Change segments_i at mid-frame (digit 1) → digits 2–3 still show old values. New values appear only after the next frame_o pulse.
4. Deassert enable_i during ON of digit 2 → all outputs inactive next cycle. Reassert → frame_o 1 cycle later, restart at digit 0.
5. Assert rst_i asynchronously mid-scan (not clock-aligned) → outputs go inactive immediately without a clock edge. After release, the scan resumes from scenario 1 timing.
6. Over 10 full frames with random segments and brightness → assert at most one active anode per cycle and a GUARD cycle between any two different active anodes.
